cp0_handler: RTL and testbench

Coprocessor-0 block for the pipelined MIPS core. It consumes the exception flags the decoder raises (RI, Ov, AdEL, AdES), the `mtc0`/`mfc0`/`eret` controls, and the six external interrupt lines. It owns SR, Cause, EPC and PRId, and decides each cycle whether the instruction in the M stage is taken to the handler. It sits beside the M stage: its `req` output flushes the pipeline, and its `epc_out` output feeds the NPC for `eret`.

---
 rtl/cp0_handler.sv | 125 ++++++++++++
 tb/tb_cp0_handler.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/cp0_handler.sv
// Coprocessor-0 for the pipelined MIPS core: SR, Cause, EPC, PRId plus exception/interrupt request logic.
// Latency: req/rd_data/epc_out are combinational; register updates become visible the cycle after the edge.
// Backpressure: none; req flushes the pipeline and suppresses the same-cycle mtc0 write and eret.
//
// Ports:
//   clk, reset (sync, active-low)        clock / reset
//   rd_addr -> rd_data                   mfc0 read port
//   wr_addr, wr_data, we                 mtc0 write port (M stage)
//   pc_m, bd_m, exc_code_m, eret_m       M-stage instruction status
//   hw_int                               external interrupt lines
//   epc_out                              EPC towards NPC, with same-cycle mtc0 bypass
//   req                                  take exception/interrupt this cycle
module cp0_handler #(
  parameter logic [31:0] PRID_VAL = 32'h2021_0707
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rd_addr,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        we,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic [4:0]  exc_code_m,
  input  logic        eret_m,
  input  logic [5:0]  hw_int,
  output logic [31:0] rd_data,
  output logic [31:0] epc_out,
  output logic        req
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  // SR fields
  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  // Cause fields
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  // EPC
  logic [31:0] epc_q, epc_d;

  logic int_req;
  logic exc_req;
  logic wr_en;

  // Interrupts are judged on the live hw_int lines, not on the latched IP,
  // so an interrupt is taken the same cycle the line rises. Gating with
  // reset keeps req low while the block is held in reset.
  assign int_req = (|(hw_int & im_q)) & ie_q & ~exl_q & reset;
  assign exc_req = (exc_code_m != 5'd0) & ~exl_q & reset;
  assign req     = int_req | exc_req;

  // A taken exception kills the instruction in M, including its mtc0.
  assign wr_en = we & ~req;

  assign epc_out = (wr_en && (wr_addr == ADDR_EPC)) ? wr_data : epc_q;

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_d       = hw_int;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;

    if (req) begin
      exl_d      = 1'b1;
      bd_d       = bd_m;
      epc_d      = bd_m ? (pc_m - 32'd4) : pc_m;
      exc_code_d = int_req ? 5'd0 : exc_code_m;
    end else begin
      if (wr_en && (wr_addr == ADDR_SR)) begin
        im_d  = wr_data[15:10];
        exl_d = wr_data[1];
        ie_d  = wr_data[0];
      end
      if (wr_en && (wr_addr == ADDR_EPC)) begin
        epc_d = wr_data;
      end
      // eret wins over a same-cycle SR write for the EXL bit only.
      if (eret_m) begin
        exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= '0;
      exc_code_q <= '0;
      epc_q      <= '0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  always_comb begin
    rd_data = 32'd0;
    case (rd_addr)
      ADDR_SR:    rd_data = {16'd0, im_q, 8'd0, exl_q, ie_q};
      ADDR_CAUSE: rd_data = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};
      ADDR_EPC:   rd_data = epc_q;
      ADDR_PRID:  rd_data = PRID_VAL;
      default:    rd_data = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_handler.sv
// Directed self-checking bench for cp0_handler.
// Latency: inputs driven 1 time unit after a rising edge, combinational outputs checked 1 unit later.
// Backpressure: not applicable.
module tb_cp0_handler;

  logic        clk;
  logic        reset;
  logic [4:0]  rd_addr;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        we;
  logic [31:0] pc_m;
  logic        bd_m;
  logic [4:0]  exc_code_m;
  logic        eret_m;
  logic [5:0]  hw_int;
  logic [31:0] rd_data;
  logic [31:0] epc_out;
  logic        req;

  int n_tests = 0;
  int n_fail  = 0;

  cp0_handler #(.PRID_VAL(32'h2021_0707)) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_addr    (rd_addr),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .we         (we),
    .pc_m       (pc_m),
    .bd_m       (bd_m),
    .exc_code_m (exc_code_m),
    .eret_m     (eret_m),
    .hw_int     (hw_int),
    .rd_data    (rd_data),
    .epc_out    (epc_out),
    .req        (req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs may then be changed safely.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
    rd_addr = a;
    #1;
    chk(tag, rd_data, exp);
  endtask

  task automatic idle();
    we = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
    exc_code_m = 5'd0; eret_m = 1'b0; bd_m = 1'b0;
  endtask

  initial begin
    reset = 1'b0; rd_addr = 5'd0; pc_m = 32'd0; hw_int = 6'd0;
    idle();

    // Reset: two cycles low, req held low even with an exception present.
    tick(); tick();
    exc_code_m = 5'd5;
    #1;
    chk("req_in_reset", {31'd0, req}, 32'd0);
    rd(5'd12, "sr_in_reset", 32'd0);
    reset = 1'b1;
    exc_code_m = 5'd0;
    rd(5'd12, "sr_reset", 32'd0);
    rd(5'd13, "cause_reset", 32'd0);
    rd(5'd14, "epc_reset", 32'd0);
    rd(5'd15, "prid", 32'h2021_0707);
    chk("req_reset", {31'd0, req}, 32'd0);

    // Masked SR write, read-only Cause, ignored unlisted address.
    we = 1'b1; wr_addr = 5'd12; wr_data = 32'hFFFF_FFFF;
    tick();
    we = 1'b0;
    rd(5'd12, "sr_masked", 32'h0000_FC03);
    we = 1'b1; wr_addr = 5'd13; wr_data = 32'hFFFF_FFFF;
    tick();
    we = 1'b1; wr_addr = 5'd3; wr_data = 32'hFFFF_FFFF;
    tick();
    we = 1'b0;
    rd(5'd13, "cause_ro", 32'd0);
    rd(5'd3, "unlisted", 32'd0);

    // Synchronous exception outside a delay slot, SR cleared first.
    we = 1'b1; wr_addr = 5'd12; wr_data = 32'd0;
    tick();
    idle();
    exc_code_m = 5'd12; pc_m = 32'h3010; bd_m = 1'b0;
    #1;
    chk("req_ov", {31'd0, req}, 32'd1);
    tick();
    idle();
    rd(5'd14, "epc_ov", 32'h3010);
    rd(5'd13, "cause_ov", 32'h0000_0030);
    rd(5'd12, "sr_exl", 32'h0000_0002);
    exc_code_m = 5'd10;
    #1;
    chk("req_nested", {31'd0, req}, 32'd0);
    exc_code_m = 5'd0;

    // Return: EXL clears, epc_out untouched.
    eret_m = 1'b1;
    #1;
    chk("epc_out_eret", epc_out, 32'h3010);
    tick();
    idle();
    rd(5'd12, "sr_after_eret", 32'd0);

    // Delay-slot exception racing an mtc0 to EPC: write must be dropped.
    exc_code_m = 5'd4; pc_m = 32'h3024; bd_m = 1'b1;
    we = 1'b1; wr_addr = 5'd14; wr_data = 32'h5000;
    #1;
    chk("req_adel", {31'd0, req}, 32'd1);
    chk("epc_out_no_bypass", epc_out, 32'h3010);
    tick();
    idle();
    rd(5'd14, "epc_bd", 32'h3020);
    rd(5'd13, "cause_bd", 32'h8000_0010);

    // Interrupt beats exception; req arises before IP is latched.
    eret_m = 1'b1;
    tick();
    idle();
    we = 1'b1; wr_addr = 5'd12; wr_data = 32'h0000_0401;
    tick();
    idle();
    rd(5'd12, "sr_401", 32'h0000_0401);
    hw_int = 6'b000001; exc_code_m = 5'd10; pc_m = 32'h4000;
    #1;
    chk("req_int", {31'd0, req}, 32'd1);
    tick();
    idle();
    rd(5'd13, "cause_int", 32'h0000_0400);
    rd(5'd14, "epc_int", 32'h4000);
    exc_code_m = 5'd12;
    #1;
    chk("req_int_nested", {31'd0, req}, 32'd0);
    exc_code_m = 5'd0;

    // mtc0 SR with eret: written value lands, EXL forced 0.
    eret_m = 1'b1; we = 1'b1; wr_addr = 5'd12; wr_data = 32'h0000_0402;
    tick();
    idle();
    rd(5'd12, "sr_wr_eret", 32'h0000_0400);

    // IE=0: only the RI exception is taken.
    exc_code_m = 5'd10; pc_m = 32'h4010;
    #1;
    chk("req_ri_ie0", {31'd0, req}, 32'd1);
    tick();
    idle();
    rd(5'd13, "cause_ri", 32'h0000_0428);
    rd(5'd14, "epc_ri", 32'h4010);

    // eret with a same-cycle mtc0 to EPC: bypassed onto epc_out.
    hw_int = 6'd0;
    eret_m = 1'b1; we = 1'b1; wr_addr = 5'd14; wr_data = 32'h3100;
    #1;
    chk("epc_out_bypass", epc_out, 32'h3100);
    tick();
    idle();
    rd(5'd14, "epc_3100", 32'h3100);
    rd(5'd12, "sr_after_ret", 32'h0000_0400);

    // Reset in the middle of a handler.
    exc_code_m = 5'd5; pc_m = 32'h5000;
    tick();
    idle();
    rd(5'd12, "sr_in_handler", 32'h0000_0402);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    hw_int = 6'b000001;
    rd(5'd12, "sr_after_rst", 32'd0);
    rd(5'd14, "epc_after_rst", 32'd0);
    chk("req_after_rst", {31'd0, req}, 32'd0);
    tick();
    rd(5'd13, "ip_reload", 32'h0000_0400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
